bht_update_ctrl: RTL and testbench

- Sequences all write traffic into the branch history table's single replace/write port.
- After reset, runs an initialisation sweep that clears every BHT entry (index × way).
- In normal operation, buffers branch resolutions from the dual-issue execute stage (up to 2 per cycle) in a small in-order queue and drains them one per cycle into the BHT update port.
- Sits between the execute stage and the bht instance in the branch-prediction unit.

---
 rtl/bp_pkg.sv | 30 +++
 rtl/bht_update_ctrl_if.sv | 47 ++++
 rtl/bht_upd_fifo.sv | 68 ++++++
 rtl/bht_update_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bht_update_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg: shared types for the branch-prediction unit.
//   addr_t            32-bit instruction address
//   bht_upd_t         one resolved-branch update {pc, dest, taken}
//   EXE_BR_LANES      number of branch-resolution lanes from execute
//   bht_ctrl_state_t  BHT write-port controller states {INIT, RUN}
//   lane_count()      number of set bits in a lane-valid vector (0..2)
// ---------------------------------------------------------------------------
package bp_pkg;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        addr_t pc;
        addr_t dest;
        logic  taken;
    } bht_upd_t;

    localparam int EXE_BR_LANES = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bht_ctrl_state_t;

    function automatic logic [1:0] lane_count(input logic [EXE_BR_LANES-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/bht_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// bht_update_ctrl_if: signal bundle around the BHT update controller.
//   exe_*    resolved branches from the dual-issue execute stage (lane 0 older)
//   upd_*    single update/write port towards the bht instance
//   init_*   clear-write sweep towards the bht instance
// Modports:
//   slave  - the controller (consumes exe_*, upd_ready; drives the rest)
//   master - the surrounding environment (execute stage + bht)
// ---------------------------------------------------------------------------
interface bht_update_ctrl_if
    import bp_pkg::*;
#(
    parameter int SET_NUM       = 8,
    parameter int ASSOCIATIVITY = 2
) ();

    localparam int INIT_AW = $clog2(SET_NUM) + $clog2(ASSOCIATIVITY);

    logic [EXE_BR_LANES-1:0]       exe_valid;
    logic [EXE_BR_LANES-1:0][31:0] exe_pc;
    logic [EXE_BR_LANES-1:0][31:0] exe_dest;
    logic [EXE_BR_LANES-1:0]       exe_taken;
    logic                          exe_ready;

    logic                          upd_valid;
    logic [31:0]                   upd_pc;
    logic [31:0]                   upd_dest;
    logic                          upd_taken;
    logic                          upd_ready;

    logic                          init_we;
    logic [INIT_AW-1:0]            init_addr;
    logic                          init_busy;

    modport slave (
        input  exe_valid, exe_pc, exe_dest, exe_taken, upd_ready,
        output exe_ready, upd_valid, upd_pc, upd_dest, upd_taken,
        output init_we, init_addr, init_busy
    );

    modport master (
        output exe_valid, exe_pc, exe_dest, exe_taken, upd_ready,
        input  exe_ready, upd_valid, upd_pc, upd_dest, upd_taken,
        input  init_we, init_addr, init_busy
    );

endinterface

// File: rtl/bht_upd_fifo.sv
// ---------------------------------------------------------------------------
// bht_upd_fifo: 2-write / 1-read in-order circular queue of bht_upd_t.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   n_enq         number of entries written this cycle (0..2), already
//                 compacted: wr_data[0] is the older, wr_data[1] the younger
//   wr_data       entries to write
//   pop           remove the head entry this cycle
//   head          current head entry (combinational from storage)
//   count         number of valid entries, 0..DEPTH
// The caller guarantees n_enq never overflows the queue.
// ---------------------------------------------------------------------------
module bht_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [1:0]             n_enq,
    input  bht_upd_t [1:0]         wr_data,
    input  logic                   pop,
    output bht_upd_t               head,
    output logic [CNT_W-1:0]       count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    bht_upd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] wr_ptr_p1;

    // Pointers are power-of-two wide, so plain addition wraps modulo DEPTH.
    assign wr_ptr_p1 = wr_ptr_reg + 1'b1;

    // Storage needs no reset; only count decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (n_enq != 2'd0) begin
            mem[wr_ptr_reg] <= wr_data[0];
        end
        if (n_enq == 2'd2) begin
            mem[wr_ptr_p1] <= wr_data[1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(n_enq);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
            count_reg  <= count_reg + CNT_W'(n_enq) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

    count_bound: assert property (@(posedge clk) disable iff (!resetn) count_reg <= DEPTH_C)
        else $error("bht_upd_fifo count exceeded DEPTH");

endmodule

// File: rtl/bht_update_ctrl.sv
// ---------------------------------------------------------------------------
// bht_update_ctrl: sequences all write traffic into the BHT replace port.
//   After reset it sweeps every {index, way} with a clear-write, then
//   queues resolved branches (up to two per cycle) and drains them one per
//   cycle onto the update port, strictly in resolution order.
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset
//   bus     bht_update_ctrl_if.slave (exe_*, upd_*, init_*)
// Build option:
//   BHT_UPD_BYPASS_EN - when defined, an update arriving while the queue is
//   empty and the BHT port is ready is issued combinationally in the same
//   cycle (oldest valid lane only; a second lane is still queued).
// ---------------------------------------------------------------------------
module bht_update_ctrl
    import bp_pkg::*;
#(
    parameter int SET_NUM       = 8,
    parameter int ASSOCIATIVITY = 2,
    parameter int DEPTH         = 4
) (
    input  logic              clk,
    input  logic              resetn,
    bht_update_ctrl_if.slave  bus
);

    localparam int INDEX_BITS = $clog2(SET_NUM);
    localparam int WAY_BITS   = $clog2(ASSOCIATIVITY);
    localparam int INIT_AW    = INDEX_BITS + WAY_BITS;
    localparam int CNT_W      = $clog2(DEPTH) + 1;

    localparam logic [INIT_AW-1:0] INIT_LAST   = INIT_AW'(SET_NUM * ASSOCIATIVITY - 1);
    localparam logic [CNT_W-1:0]   ENQ2_LIMIT  = CNT_W'(DEPTH - 2);

    // -------------------------------------------------------------------
    // FSM + sweep counter
    // -------------------------------------------------------------------
    bht_ctrl_state_t    state_reg;
    logic [INIT_AW-1:0] init_addr_reg;
    logic               init_busy_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= INIT;
            init_addr_reg <= '0;
            init_busy_reg <= 1'b1;
        end else begin
            case (state_reg)
                INIT: begin
                    if (init_addr_reg == INIT_LAST) begin
                        state_reg     <= RUN;
                        init_addr_reg <= '0;
                        init_busy_reg <= 1'b0;
                    end else begin
                        init_addr_reg <= init_addr_reg + 1'b1;
                    end
                end
                RUN: begin
                    init_addr_reg <= '0;
                    init_busy_reg <= 1'b0;
                end
                default: begin
                    state_reg     <= INIT;
                    init_addr_reg <= '0;
                    init_busy_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.init_we   = init_busy_reg;
    assign bus.init_busy = init_busy_reg;
    assign bus.init_addr = init_addr_reg;

    // -------------------------------------------------------------------
    // Lane unpacking
    // -------------------------------------------------------------------
    bht_upd_t [EXE_BR_LANES-1:0] lane_upd;

    genvar gi;
    generate
        for (gi = 0; gi < EXE_BR_LANES; gi++) begin : g_lane
            assign lane_upd[gi] = {bus.exe_pc[gi], bus.exe_dest[gi], bus.exe_taken[gi]};
        end
    endgenerate

    // -------------------------------------------------------------------
    // Accept / bypass / enqueue
    // -------------------------------------------------------------------
    logic [CNT_W-1:0]        fifo_count;
    bht_upd_t                fifo_head;
    logic                    run;
    logic                    exe_ready_int;
    logic                    queue_empty;
    logic [EXE_BR_LANES-1:0] acc_valid;
    logic [EXE_BR_LANES-1:0] enq_valid;
    logic                    byp_take;
    bht_upd_t                byp_data;
    logic [1:0]              n_enq;
    bht_upd_t [1:0]          wr_data;
    logic                    pop;
    bht_upd_t                upd_sel;

    assign run         = (state_reg == RUN);
    assign queue_empty = (fifo_count == '0);
    // Room for two is required before accepting anything, so upstream never
    // has to split a pair; this does not look at upd_ready.
    assign exe_ready_int = run && (fifo_count <= ENQ2_LIMIT);
    assign acc_valid     = bus.exe_valid & {EXE_BR_LANES{exe_ready_int}};

    always_comb begin
        enq_valid = acc_valid;
        byp_take  = 1'b0;
        byp_data  = '0;
`ifdef BHT_UPD_BYPASS_EN
        // Only legal with an empty queue, otherwise ordering would break.
        if (queue_empty && bus.upd_ready && (acc_valid != '0)) begin
            byp_take  = 1'b1;
            byp_data  = acc_valid[0] ? lane_upd[0] : lane_upd[1];
            // Drop the oldest valid lane from the enqueue set.
            enq_valid = acc_valid & (acc_valid - 1'b1);
        end
`endif
    end

    // Compaction: a lone lane 1 lands in the first free slot.
    assign n_enq      = lane_count(enq_valid);
    assign wr_data[0] = enq_valid[0] ? lane_upd[0] : lane_upd[1];
    assign wr_data[1] = lane_upd[1];

    assign pop = !queue_empty && bus.upd_ready;

    bht_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .n_enq   (n_enq),
        .wr_data (wr_data),
        .pop     (pop),
        .head    (fifo_head),
        .count   (fifo_count)
    );

    // -------------------------------------------------------------------
    // Update port: queue head has priority; outputs are zero when idle so
    // stale storage never reaches the BHT.
    // -------------------------------------------------------------------
    always_comb begin
        upd_sel = '0;
        if (!queue_empty) begin
            upd_sel = fifo_head;
        end else if (byp_take) begin
            upd_sel = byp_data;
        end
    end

    assign bus.exe_ready = exe_ready_int;
    assign bus.upd_valid = !queue_empty || byp_take;
    assign bus.upd_pc    = upd_sel.pc;
    assign bus.upd_dest  = upd_sel.dest;
    assign bus.upd_taken = upd_sel.taken;

endmodule

// File: tb/tb_bht_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bht_update_ctrl: directed self-checking bench for bht_update_ctrl at
// default parameters (8 sets x 2 ways, 4-entry queue). Inputs are driven
// 1 time unit after the rising edge; outputs are sampled one further unit
// later, well away from the next edge. Expected timings follow the
// BHT_UPD_BYPASS_EN build option when it is defined.
// ---------------------------------------------------------------------------
module tb_bht_update_ctrl;
    import bp_pkg::*;

    logic clk;
    logic resetn;

    int n_cmp = 0;
    int n_err = 0;

    bht_update_ctrl_if #(.SET_NUM(8), .ASSOCIATIVITY(2)) bus ();

    bht_update_ctrl #(
        .SET_NUM       (8),
        .ASSOCIATIVITY (2),
        .DEPTH         (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_exe(input logic [1:0] v,
                             input logic [31:0] pc0, input logic [31:0] d0, input logic t0,
                             input logic [31:0] pc1, input logic [31:0] d1, input logic t1);
        bus.exe_valid    = v;
        bus.exe_pc[0]    = pc0;
        bus.exe_dest[0]  = d0;
        bus.exe_taken[0] = t0;
        bus.exe_pc[1]    = pc1;
        bus.exe_dest[1]  = d1;
        bus.exe_taken[1] = t1;
    endtask

    task automatic idle_exe();
        drive_exe(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic check_upd(input string tag, input logic v,
                             input logic [31:0] pc, input logic [31:0] dest, input logic tk);
        check_val({tag, "_valid"}, 32'(bus.upd_valid), 32'(v));
        check_val({tag, "_pc"},    bus.upd_pc, pc);
        check_val({tag, "_dest"},  bus.upd_dest, dest);
        check_val({tag, "_taken"}, 32'(bus.upd_taken), 32'(tk));
        $display("%s: upd_valid=%0b pc=0x%08h dest=0x%08h taken=%0b",
                 tag, bus.upd_valid, bus.upd_pc, bus.upd_dest, bus.upd_taken);
    endtask

    // Entered in the window where resetn has just been released. exe_valid is
    // held high for most of the sweep to show it is ignored.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (i < 15) drive_exe(2'b11, 32'h1111_0000, 32'h2222_0000, 1'b1,
                                  32'h3333_0000, 32'h4444_0000, 1'b1);
            else        idle_exe();
            #1;
            check_val($sformatf("%s_we%0d", tag, i),    32'(bus.init_we), 32'd1);
            check_val($sformatf("%s_addr%0d", tag, i),  32'(bus.init_addr), 32'(i));
            check_val($sformatf("%s_busy%0d", tag, i),  32'(bus.init_busy), 32'd1);
            check_val($sformatf("%s_rdy%0d", tag, i),   32'(bus.exe_ready), 32'd0);
            check_val($sformatf("%s_uv%0d", tag, i),    32'(bus.upd_valid), 32'd0);
            tick();
        end
        check_val({tag, "_run_busy"}, 32'(bus.init_busy), 32'd0);
        check_val({tag, "_run_we"},   32'(bus.init_we), 32'd0);
        check_val({tag, "_run_addr"}, 32'(bus.init_addr), 32'd0);
        check_val({tag, "_run_rdy"},  32'(bus.exe_ready), 32'd1);
        check_val({tag, "_run_uv"},   32'(bus.upd_valid), 32'd0);
        $display("%s: sweep of 16 entries done, exe_ready=%0b", tag, bus.exe_ready);
    endtask

    bht_upd_t exq[$];

    initial begin
        logic [31:0] exp_pc [4];
        logic        exp_rdy [4];
        int sent;
        int got;
        bit seen_not_ready;

        resetn        = 1'b0;
        bus.upd_ready = 1'b1;
        idle_exe();

        // ---------------- 1: reset values and init sweep -----------------
        tick();
        #1;
        check_val("rst_busy", 32'(bus.init_busy), 32'd1);
        check_val("rst_we",   32'(bus.init_we), 32'd1);
        check_val("rst_addr", 32'(bus.init_addr), 32'd0);
        check_val("rst_rdy",  32'(bus.exe_ready), 32'd0);
        check_upd("rst_upd", 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        resetn = 1'b1;
        sweep_check("t1");

        // ---------------- 2: single lane-0 update -------------------------
        bus.upd_ready = 1'b1;
        drive_exe(2'b01, 32'hBFC0_0010, 32'hBFC0_0040, 1'b1, 32'h0, 32'h0, 1'b0);
        #1;
`ifdef BHT_UPD_BYPASS_EN
        check_upd("t2_same", 1'b1, 32'hBFC0_0010, 32'hBFC0_0040, 1'b1);
        idle_exe();
        tick();
        check_upd("t2_after", 1'b0, 32'h0, 32'h0, 1'b0);
`else
        check_upd("t2_same", 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle_exe();
        #1;
        check_upd("t2_next", 1'b1, 32'hBFC0_0010, 32'hBFC0_0040, 1'b1);
        tick();
        check_upd("t2_after", 1'b0, 32'h0, 32'h0, 1'b0);
`endif

        // ---------------- 3: fill to 4 with upd_ready low, then drain -----
        bus.upd_ready = 1'b0;
        drive_exe(2'b11, 32'h0000_1000, 32'h0000_2000, 1'b1, 32'h0000_1100, 32'h0000_2100, 1'b0);
        tick();
        drive_exe(2'b11, 32'h0000_1200, 32'h0000_2200, 1'b1, 32'h0000_1300, 32'h0000_2300, 1'b0);
        tick();
        idle_exe();
        #1;
        check_val("t3_full_rdy", 32'(bus.exe_ready), 32'd0);
        check_upd("t3_full_head", 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1);
        bus.upd_ready = 1'b1;
        #1;
        exp_pc  = '{32'h0000_1000, 32'h0000_1100, 32'h0000_1200, 32'h0000_1300};
        exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            check_upd($sformatf("t3_drain%0d", k), 1'b1, exp_pc[k],
                      exp_pc[k] + 32'h0000_1000, (k % 2) == 0);
            check_val($sformatf("t3_rdy%0d", k), 32'(bus.exe_ready), 32'(exp_rdy[k]));
            tick();
        end
        check_upd("t3_empty", 1'b0, 32'h0, 32'h0, 1'b0);

        // ---------------- 4: lane-1-only then both lanes ------------------
        drive_exe(2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h8000_1000, 32'h8000_2000, 1'b1);
        #1;
`ifdef BHT_UPD_BYPASS_EN
        check_upd("t4_l1", 1'b1, 32'h8000_1000, 32'h8000_2000, 1'b1);
        tick();
        drive_exe(2'b11, 32'h8000_3000, 32'h8000_4000, 1'b0, 32'h8000_5000, 32'h8000_6000, 1'b1);
        #1;
        check_upd("t4_e", 1'b1, 32'h8000_3000, 32'h8000_4000, 1'b0);
        tick();
        idle_exe();
        #1;
        check_upd("t4_f", 1'b1, 32'h8000_5000, 32'h8000_6000, 1'b1);
        tick();
        check_upd("t4_empty", 1'b0, 32'h0, 32'h0, 1'b0);
`else
        check_upd("t4_w0", 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        drive_exe(2'b11, 32'h8000_3000, 32'h8000_4000, 1'b0, 32'h8000_5000, 32'h8000_6000, 1'b1);
        #1;
        check_upd("t4_l1", 1'b1, 32'h8000_1000, 32'h8000_2000, 1'b1);
        tick();
        idle_exe();
        #1;
        check_upd("t4_e", 1'b1, 32'h8000_3000, 32'h8000_4000, 1'b0);
        tick();
        check_upd("t4_f", 1'b1, 32'h8000_5000, 32'h8000_6000, 1'b1);
        tick();
        check_upd("t4_empty", 1'b0, 32'h0, 32'h0, 1'b0);
`endif

        // ---------------- 5: reset mid-drain with count = 3 ---------------
        bus.upd_ready = 1'b0;
        drive_exe(2'b11, 32'h9000_0000, 32'h9100_0000, 1'b1, 32'h9000_0004, 32'h9100_0004, 1'b0);
        tick();
        drive_exe(2'b11, 32'h9000_0008, 32'h9100_0008, 1'b1, 32'h9000_000C, 32'h9100_000C, 1'b0);
        tick();
        idle_exe();
        bus.upd_ready = 1'b1;
        #1;
        check_upd("t5_g", 1'b1, 32'h9000_0000, 32'h9100_0000, 1'b1);
        tick();
        check_upd("t5_h", 1'b1, 32'h9000_0004, 32'h9100_0004, 1'b0);
        resetn = 1'b0;
        #1;
        check_upd("t5_rst", 1'b0, 32'h0, 32'h0, 1'b0);
        check_val("t5_rst_busy", 32'(bus.init_busy), 32'd1);
        check_val("t5_rst_addr", 32'(bus.init_addr), 32'd0);
        check_val("t5_rst_rdy",  32'(bus.exe_ready), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        sweep_check("t5");
        tick();
        check_upd("t5_post_empty", 1'b0, 32'h0, 32'h0, 1'b0);

        // ---------------- 6: streaming scoreboard, 100 updates ------------
        bus.upd_ready  = 1'b1;
        sent           = 0;
        got            = 0;
        seen_not_ready = 1'b0;
        exq.delete();
        for (int cyc = 0; cyc < 400 && got < 100; cyc++) begin
            logic [1:0] v;
            bht_upd_t   l0;
            bht_upd_t   l1;
            v  = 2'b00;
            l0 = {$urandom(), $urandom(), 1'($urandom_range(0, 1))};
            l1 = {$urandom(), $urandom(), 1'($urandom_range(0, 1))};
            if (!bus.exe_ready) seen_not_ready = 1'b1;
            if (bus.exe_ready && sent < 100) v = (sent == 99) ? 2'b01 : 2'b11;
            drive_exe(v, l0.pc, l0.dest, l0.taken, l1.pc, l1.dest, l1.taken);
            if (v[0]) begin exq.push_back(l0); sent++; end
            if (v[1]) begin exq.push_back(l1); sent++; end
            #1;
            if (bus.upd_valid) begin
                if (exq.size() == 0) begin
                    check_val("t6_spurious", 32'(bus.upd_valid), 32'd0);
                end else begin
                    bht_upd_t e;
                    e = exq.pop_front();
                    check_upd($sformatf("t6_upd%0d", got), 1'b1, e.pc, e.dest, e.taken);
                    got++;
                end
            end
            tick();
            idle_exe();
        end
        check_val("t6_got",     32'(got), 32'd100);
        check_val("t6_left",    32'(exq.size()), 32'd0);
        check_val("t6_toggled", 32'(seen_not_ready), 32'd1);
        #1;
        check_upd("t6_idle", 1'b0, 32'h0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
